data_bus_memory: RTL and testbench

//  Data-side bus slave directly downstream of the load/store interface stage.

---
 rtl/data_bus_memory_if.sv | 23 ++
 rtl/data_bus_memory.sv | 136 +++++++++++++
 tb/tb_data_bus_memory.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/data_bus_memory_if.sv
// Data-side bus between the load/store stage (master) and data_bus_memory (slave).
interface data_bus_memory_if;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        bus_stall;
    logic        bus_fault;

    modport master (
        output bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        input  bus_read_data, bus_stall, bus_fault
    );

    modport slave (
        input  bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        output bus_read_data, bus_stall, bus_fault
    );
endinterface

// File: rtl/data_bus_memory.sv
// Data bus slave: word-organised RAM plus LED/switch/cycle-counter MMIO.
// Reads take two cycles (stall in the first); writes complete in one.
module data_bus_memory #(
    parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic             clock,
    input  logic             reset,
    data_bus_memory_if.slave bus,
    input  logic [31:0]      io_switches,
    output logic [31:0]      io_leds
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_READ_WAIT = 1'b1;

    logic [31:0] mem [RAM_WORDS];

    logic [0:0]  state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        rd_fault_q, rd_fault_d;
    logic [31:0] leds_q, leds_d;
    logic [31:0] sw_meta_q, sw_meta_d;
    logic [31:0] sw_sync_q, sw_sync_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] cycle_hi_q, cycle_hi_d;

    logic [31:0]      word_addr, ram_off, mmio_off, rd_word;
    logic             ram_hit, mmio_hit, wr_legal;
    logic [IDX_W-1:0] ram_idx;
    logic [1:0]       mmio_sel;
    logic             rd_req, wr_req, both_req;

    assign word_addr = bus.bus_address & ~32'h3;
    assign ram_off   = word_addr - RAM_BASE;
    assign mmio_off  = word_addr - MMIO_BASE;
    assign ram_hit   = (word_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
    assign mmio_hit  = (word_addr >= MMIO_BASE) && (mmio_off < 32'h10);
    assign ram_idx   = ram_off[IDX_W+1:2];
    assign mmio_sel  = mmio_off[3:2];
    assign wr_legal  = ram_hit || (mmio_hit && (mmio_sel == 2'd0));

    assign rd_req   = !reset && (state_q == ST_IDLE) &&  bus.bus_read_enable && !bus.bus_write_enable;
    assign wr_req   = !reset && (state_q == ST_IDLE) && !bus.bus_read_enable &&  bus.bus_write_enable;
    assign both_req = !reset && (state_q == ST_IDLE) &&  bus.bus_read_enable &&  bus.bus_write_enable;

    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_sel)
                2'd0:    rd_word = leds_q;
                2'd1:    rd_word = sw_sync_q;
                2'd2:    rd_word = cycle_q[31:0];
                default: rd_word = cycle_hi_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        rd_fault_d  = 1'b0;
        leds_d      = leds_q;
        sw_meta_d   = io_switches;
        sw_sync_d   = sw_meta_q;
        cycle_d     = cycle_q + 64'd1;
        cycle_hi_d  = cycle_hi_q;

        if (state_q == ST_IDLE) begin
            if (rd_req) begin
                state_d     = ST_READ_WAIT;
                read_data_d = (ram_hit || mmio_hit) ? rd_word : '0;
                rd_fault_d  = !(ram_hit || mmio_hit);
                // HI shadow is latched with the same counter value LO returns
                if (mmio_hit && (mmio_sel == 2'd2)) begin
                    cycle_hi_d = cycle_q[63:32];
                end
            end
            if (wr_req && mmio_hit && (mmio_sel == 2'd0)) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (bus.bus_byte_enable[i]) begin
                        leds_d[8*i +: 8] = bus.bus_write_data[8*i +: 8];
                    end
                end
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            read_data_q <= '0;
            rd_fault_q  <= 1'b0;
            leds_q      <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            cycle_q     <= '0;
            cycle_hi_q  <= '0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            rd_fault_q  <= rd_fault_d;
            leds_q      <= leds_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            cycle_q     <= cycle_d;
            cycle_hi_q  <= cycle_hi_d;
        end
    end

    // RAM contents survive reset; only mapped, single-request writes land.
    always_ff @(posedge clock) begin
        if (wr_req && ram_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.bus_byte_enable[i]) begin
                    mem[ram_idx][8*i +: 8] <= bus.bus_write_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.bus_read_data = read_data_q;
    assign bus.bus_stall     = rd_req;
    assign bus.bus_fault     = both_req || (wr_req && !wr_legal) ||
                               (!reset && (state_q == ST_READ_WAIT) && rd_fault_q);
    assign io_leds           = leds_q;

endmodule

// File: tb/tb_data_bus_memory.sv
// Directed bench for data_bus_memory: RAM, decode faults, MMIO, counter shadow, reset mid-read.
module tb_data_bus_memory;

    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic [31:0] io_switches;
    logic [31:0] io_leds;
    logic [31:0] got;

    int n_total = 0;
    int n_pass  = 0;

    data_bus_memory_if bus_if ();

    data_bus_memory #(
        .RAM_BASE  (RAM_BASE),
        .RAM_WORDS (1024),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if),
        .io_switches (io_switches),
        .io_leds     (io_leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
        n_total++;
        assert (obs === exp_a || obs === exp_b) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h or %h", tag, obs, exp_a, exp_b);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic bus_idle();
        bus_if.bus_address      = '0;
        bus_if.bus_write_data   = '0;
        bus_if.bus_byte_enable  = '0;
        bus_if.bus_read_enable  = 1'b0;
        bus_if.bus_write_enable = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic exp_fault);
        bus_if.bus_address      = addr;
        bus_if.bus_write_data   = data;
        bus_if.bus_byte_enable  = be;
        bus_if.bus_write_enable = 1'b1;
        #1;
        chk({tag, " wr stall"}, 32'(bus_if.bus_stall), 32'd0);
        chk({tag, " wr fault"}, 32'(bus_if.bus_fault), 32'(exp_fault));
        tick();
        bus_idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic check_data,
                      input logic [31:0] exp_data, input logic exp_fault,
                      output logic [31:0] data);
        bus_if.bus_address     = addr;
        bus_if.bus_read_enable = 1'b1;
        #1;
        chk({tag, " rd stall issue"}, 32'(bus_if.bus_stall), 32'd1);
        chk({tag, " rd fault issue"}, 32'(bus_if.bus_fault), 32'd0);
        tick();
        chk({tag, " rd stall wait"}, 32'(bus_if.bus_stall), 32'd0);
        chk({tag, " rd fault wait"}, 32'(bus_if.bus_fault), 32'(exp_fault));
        data = bus_if.bus_read_data;
        if (check_data) chk({tag, " rd data"}, data, exp_data);
        bus_idle();
        tick();
        chk({tag, " rd fault after"}, 32'(bus_if.bus_fault), 32'd0);
        chk({tag, " rd data hold"}, bus_if.bus_read_data, data);
    endtask

    initial begin
        reset       = 1'b1;
        io_switches = '0;
        bus_idle();
        repeat (3) tick();
        chk("reset read_data", bus_if.bus_read_data, 32'd0);
        chk("reset stall", 32'(bus_if.bus_stall), 32'd0);
        chk("reset fault", 32'(bus_if.bus_fault), 32'd0);
        chk("reset leds", io_leds, 32'd0);
        reset = 1'b0;

        rd("cycle lo after reset", MMIO_BASE + 32'h8, 1'b1, 32'd0, 1'b0, got);
        rd("cycle hi after reset", MMIO_BASE + 32'hC, 1'b1, 32'd0, 1'b0, got);

        wr("ram full", RAM_BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd("ram full", RAM_BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0, got);

        wr("ram lane1", RAM_BASE + 32'h10, 32'h0000_AB00, 4'b0010, 1'b0);
        rd("ram lane1", RAM_BASE + 32'h10, 1'b1, 32'hDEAD_ABEF, 1'b0, got);
        wr("ram be0", RAM_BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        rd("ram be0", RAM_BASE + 32'h10, 1'b1, 32'hDEAD_ABEF, 1'b0, got);

        wr("ram word0", RAM_BASE, 32'h1122_3344, 4'b1111, 1'b0);
        wr("ram last", RAM_BASE + 32'hFFC, 32'hCAFE_F00D, 4'b1111, 1'b0);
        rd("ram last", RAM_BASE + 32'hFFC, 1'b1, 32'hCAFE_F00D, 1'b0, got);
        rd("past end", RAM_BASE + 32'h1000, 1'b1, 32'd0, 1'b1, got);
        wr("past end", RAM_BASE + 32'h1000, 32'h0, 4'b1111, 1'b1);
        rd("word0 intact", RAM_BASE, 1'b1, 32'h1122_3344, 1'b0, got);
        rd("before base", RAM_BASE - 32'h4, 1'b1, 32'd0, 1'b1, got);
        rd("mmio hole", MMIO_BASE + 32'h10, 1'b1, 32'd0, 1'b1, got);

        bus_if.bus_address      = RAM_BASE + 32'h10;
        bus_if.bus_write_data   = 32'h0;
        bus_if.bus_byte_enable  = 4'b1111;
        bus_if.bus_read_enable  = 1'b1;
        bus_if.bus_write_enable = 1'b1;
        #1;
        chk("rd+wr stall", 32'(bus_if.bus_stall), 32'd0);
        chk("rd+wr fault", 32'(bus_if.bus_fault), 32'd1);
        tick();
        bus_idle();
        rd("rd+wr no write", RAM_BASE + 32'h10, 1'b1, 32'hDEAD_ABEF, 1'b0, got);

        wr("leds byte0", MMIO_BASE, 32'h0000_005A, 4'b0001, 1'b0);
        chk("leds byte0", io_leds, 32'h0000_005A);
        wr("leds lanes12", MMIO_BASE, 32'h1234_5600, 4'b0110, 1'b0);
        chk("leds lanes12", io_leds, 32'h0034_565A);
        wr("write switches", MMIO_BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        wr("write cycle lo", MMIO_BASE + 32'h8, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        chk("leds after ro writes", io_leds, 32'h0034_565A);
        rd("leds readback", MMIO_BASE, 1'b1, 32'h0034_565A, 1'b0, got);

        io_switches = 32'h3;
        rd("switches sync early", MMIO_BASE + 32'h4, 1'b1, 32'h0, 1'b0, got);
        rd("switches sync late", MMIO_BASE + 32'h4, 1'b1, 32'h3, 1'b0, got);

        bus_if.bus_address     = RAM_BASE + 32'h10;
        bus_if.bus_read_enable = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("reset mid-read stall", 32'(bus_if.bus_stall), 32'd0);
        chk("reset mid-read fault", 32'(bus_if.bus_fault), 32'd0);
        chk("reset mid-read data", bus_if.bus_read_data, 32'd0);
        chk("reset mid-read leds", io_leds, 32'd0);
        reset = 1'b0;
        bus_idle();
        rd("read after reset", RAM_BASE + 32'h10, 1'b1, 32'hDEAD_ABEF, 1'b0, got);

        // Release of a forced flop may settle on either the forced or the next value, so LO allows +1.
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        tick();
        release dut.cycle_q;
        rd("carry lo", MMIO_BASE + 32'h8, 1'b0, 32'd0, 1'b0, got);
        chk2("carry lo value", got, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        rd("carry hi shadow", MMIO_BASE + 32'hC, 1'b1, 32'h0, 1'b0, got);
        rd("carry lo2", MMIO_BASE + 32'h8, 1'b0, 32'd0, 1'b0, got);
        chk2("carry lo2 value", got, 32'h2, 32'h3);
        rd("carry hi2", MMIO_BASE + 32'hC, 1'b1, 32'h1, 1'b0, got);

        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        release dut.cycle_q;
        rd("wrap lo", MMIO_BASE + 32'h8, 1'b0, 32'd0, 1'b0, got);
        chk2("wrap lo value", got, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        rd("wrap hi", MMIO_BASE + 32'hC, 1'b1, 32'hFFFF_FFFF, 1'b0, got);
        rd("wrap lo2", MMIO_BASE + 32'h8, 1'b0, 32'd0, 1'b0, got);
        chk2("wrap lo2 value", got, 32'h2, 32'h3);
        rd("wrap hi2", MMIO_BASE + 32'hC, 1'b1, 32'h0, 1'b0, got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
